// File: rtl/ex_stage_if.sv
// Handshake and data bundle between decode, the execute stage and the memory stage.
// The execute stage takes the slave view; the producer/consumer side takes the master view.
interface ex_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;
   logic            in_a_sel;
   logic            in_b_sel;
   logic [3:0]      in_alu_sel;
   logic            in_mem_wr;
   logic [1:0]      in_wb_sel;
   logic [4:0]      in_rd;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_alu;
   logic [XLEN-1:0] out_store;
   logic [XLEN-1:0] out_pc4;
   logic            out_mem_wr;
   logic [1:0]      out_wb_sel;
   logic [4:0]      out_rd;

   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_a_sel, in_b_sel, in_alu_sel,
             in_mem_wr, in_wb_sel, in_rd, out_ready,
      input  in_ready, out_valid, out_alu, out_store, out_pc4, out_mem_wr, out_wb_sel, out_rd
   );

   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_a_sel, in_b_sel, in_alu_sel,
             in_mem_wr, in_wb_sel, in_rd, out_ready,
      output in_ready, out_valid, out_alu, out_store, out_pc4, out_mem_wr, out_wb_sel, out_rd
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, and a single registered EX/MEM entry with
// valid/ready on both sides, flush squash and a saturating retired-op counter.
module ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   ex_stage_if.slave        bus,
   output logic [CNT_W-1:0] retired_cnt
);
   localparam logic [CNT_W-1:0] CntOne = 1;
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic [4:0]      shamt;
   logic            capture;
   logic            retire;

   logic            valid_q, valid_d;
   logic [XLEN-1:0] alu_q;
   logic [XLEN-1:0] store_q;
   logic [XLEN-1:0] pc4_q;
   logic            mem_wr_q;
   logic [1:0]      wb_sel_q;
   logic [4:0]      rd_q;
   logic [CNT_W-1:0] cnt_q;

   assign op_a  = bus.in_a_sel ? bus.in_pc : bus.in_rs1;
   assign op_b  = bus.in_b_sel ? bus.in_imm : bus.in_rs2;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = '0;
      case (bus.in_alu_sel)
         4'b0000: alu_res = op_a << shamt;
         4'b0001: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'b0010: alu_res = op_a + op_b;
         4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         4'b0100: alu_res = op_a ^ op_b;
         4'b0101: alu_res = op_a >> shamt;
         4'b0110: alu_res = op_a | op_b;
         4'b0111: alu_res = op_a & op_b;
         4'b1000: alu_res = op_a - op_b;
         4'b1001: alu_res = op_b;
         4'b1101: alu_res = $unsigned($signed(op_a) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   // No skid buffer: upstream may only advance when the single entry frees up this cycle.
   assign bus.in_ready = !flush && (!valid_q || bus.out_ready);
   assign capture      = bus.in_valid && bus.in_ready;
   assign retire       = valid_q && bus.out_ready;

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
      end else if (retire) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         alu_q    <= '0;
         store_q  <= '0;
         pc4_q    <= '0;
         mem_wr_q <= 1'b0;
         wb_sel_q <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q <= valid_d;
         if (capture) begin
            alu_q    <= alu_res;
            store_q  <= bus.in_rs2;
            pc4_q    <= bus.in_pc + XLEN'(4);
            mem_wr_q <= bus.in_mem_wr;
            wb_sel_q <= bus.in_wb_sel;
            rd_q     <= bus.in_rd;
         end
         // A handshake completing in a flush cycle still retires.
         if (retire && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CntOne;
         end
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_alu    = alu_q;
   assign bus.out_store  = store_q;
   assign bus.out_pc4    = pc4_q;
   assign bus.out_mem_wr = mem_wr_q && valid_q;
   assign bus.out_wb_sel = wb_sel_q;
   assign bus.out_rd     = rd_q;
   assign retired_cnt    = cnt_q;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes expected entries on accepted ops,
// a negedge monitor pops and compares whenever an entry is handed downstream.
module tb_ex_stage;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        a_sel;
      logic        b_sel;
      logic [3:0]  alu;
      logic        mem_wr;
      logic [1:0]  wb;
      logic [4:0]  rd;
   } op_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] store;
      logic [31:0] pc4;
      logic        mem_wr;
      logic [1:0]  wb;
      logic [4:0]  rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] retired_cnt;

   ex_stage_if #(.XLEN(32)) bus ();

   ex_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   exp_t        q[$];
   logic        pend_ok = 1'b0;
   exp_t        pend_exp;
   logic [31:0] exp_cnt = 0;
   logic [31:0] base;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU written from the operation table with plain arithmetic.
   function automatic exp_t model(input op_t o);
      exp_t        e;
      logic [31:0] a, b, r;
      int          sa, sb;
      int unsigned sh;
      a  = o.a_sel ? o.pc : o.rs1;
      b  = o.b_sel ? o.imm : o.rs2;
      sh = b % 32;
      sa = a;
      sb = b;
      case (o.alu)
         4'd0:    r = a << sh;
         4'd1:    r = (sa < sb) ? 32'd1 : 32'd0;
         4'd2:    r = a + b;
         4'd3:    r = (a < b) ? 32'd1 : 32'd0;
         4'd4:    r = a ^ b;
         4'd5:    r = a >> sh;
         4'd6:    r = a | b;
         4'd7:    r = a & b;
         4'd8:    r = a + ~b + 32'd1;
         4'd9:    r = b;
         4'd13:   r = a[31] ? ~((~a) >> sh) : (a >> sh);
         default: r = 32'd0;
      endcase
      e.alu    = r;
      e.store  = o.rs2;
      e.pc4    = o.pc + 32'd4;
      e.mem_wr = o.mem_wr;
      e.wb     = o.wb;
      e.rd     = o.rd;
      return e;
   endfunction

   function automatic op_t mk(input logic [31:0] pc, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic a_sel, input logic b_sel, input logic [3:0] alu);
      op_t o;
      o.pc     = pc;
      o.rs1    = rs1;
      o.rs2    = rs2;
      o.imm    = imm;
      o.a_sel  = a_sel;
      o.b_sel  = b_sel;
      o.alu    = alu;
      o.mem_wr = 1'b1;
      o.wb     = 2'd1;
      o.rd     = 5'd3;
      return o;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h8000_0000;
         1:       v = 32'hFFFF_FFFF;
         2:       v = 32'd0;
         3:       v = 32'd1;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.pc     = $urandom & 32'hFFFF_FFFC;
      o.rs1    = rand_word();
      o.rs2    = rand_word();
      o.imm    = rand_word();
      o.a_sel  = 1'($urandom_range(0, 1));
      o.b_sel  = 1'($urandom_range(0, 1));
      o.alu    = 4'($urandom_range(0, 15));
      o.mem_wr = 1'($urandom_range(0, 1));
      o.wb     = 2'($urandom_range(0, 3));
      o.rd     = 5'($urandom_range(0, 31));
      return o;
   endfunction

   // One cycle of stimulus: drive after the edge, note acceptance mid-cycle,
   // and publish the expected entry at the edge that captures it.
   task automatic step(input op_t o, input logic v, input logic r, input logic f);
      @(posedge clk);
      if (pend_ok) q.push_back(pend_exp);
      pend_ok = 1'b0;
      #1;
      bus.in_valid   = v;
      bus.out_ready  = r;
      flush          = f;
      bus.in_pc      = o.pc;
      bus.in_rs1     = o.rs1;
      bus.in_rs2     = o.rs2;
      bus.in_imm     = o.imm;
      bus.in_a_sel   = o.a_sel;
      bus.in_b_sel   = o.b_sel;
      bus.in_alu_sel = o.alu;
      bus.in_mem_wr  = o.mem_wr;
      bus.in_wb_sel  = o.wb;
      bus.in_rd      = o.rd;
      @(negedge clk);
      if (v && bus.in_ready) begin
         pend_ok  = 1'b1;
         pend_exp = model(o);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(rand_op(), 1'b0, 1'b1, 1'b0);
   endtask

   always @(negedge clk) begin : monitor
      logic have;
      exp_t e;
      if (rst_n) begin
         have = (q.size() != 0);
         chk("out_valid", 32'(bus.out_valid), 32'(have));
         chk("in_ready", 32'(bus.in_ready), 32'(!flush && (!have || bus.out_ready)));
         chk("retired_cnt", retired_cnt, exp_cnt);
         if (!bus.out_valid) chk("mem_wr_idle", 32'(bus.out_mem_wr), 32'd0);
         if (have && bus.out_ready) begin
            e = q.pop_front();
            chk("sb_alu", bus.out_alu, e.alu);
            chk("sb_store", bus.out_store, e.store);
            chk("sb_pc4", bus.out_pc4, e.pc4);
            chk("sb_ctl", {24'd0, bus.out_mem_wr, bus.out_wb_sel, bus.out_rd},
                {24'd0, e.mem_wr, e.wb, e.rd});
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
         end else if (have && flush) begin
            void'(q.pop_front());
         end
      end
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu", bus.out_alu, 32'd0);
      chk("rst_cnt", retired_cnt, 32'd0);
      #11 rst_n = 1'b1;

      // ADD 5+7
      step(mk(32'h0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 4'b0010), 1'b1, 1'b1, 1'b0);
      step(rand_op(), 1'b0, 1'b1, 1'b0);
      chk("add", bus.out_alu, 32'd12);
      chk("add_valid", 32'(bus.out_valid), 32'd1);

      // LUI then AUIPC back to back
      step(mk(32'h0, 32'd0, 32'd0, 32'h1234_5000, 1'b0, 1'b1, 4'b1001), 1'b1, 1'b1, 1'b0);
      step(mk(32'h100, 32'd0, 32'd0, 32'h1000, 1'b1, 1'b1, 4'b0010), 1'b1, 1'b1, 1'b0);
      chk("lui", bus.out_alu, 32'h1234_5000);
      step(rand_op(), 1'b0, 1'b1, 1'b0);
      chk("auipc", bus.out_alu, 32'h0000_1100);
      idle(2);

      // Backpressure for three cycles, then release
      base = exp_cnt;
      step(mk(32'h40, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 4'b0010), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(mk(32'h44, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0, 4'b0100), 1'b1, 1'b0, 1'b0);
      chk("bp_hold_alu", bus.out_alu, 32'd3);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      step(mk(32'h44, 32'hF0, 32'h0F, 32'd0, 1'b0, 1'b0, 4'b0100), 1'b1, 1'b1, 1'b0);
      step(rand_op(), 1'b0, 1'b1, 1'b0);
      chk("bp_next", bus.out_alu, 32'h0000_00FF);
      idle(1);
      chk("bp_cnt", retired_cnt, base + 32'd2);

      // Flush while holding with in_valid high
      base = exp_cnt;
      step(mk(32'h80, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 4'b0010), 1'b1, 1'b0, 1'b0);
      step(mk(32'h84, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0010), 1'b1, 1'b0, 1'b0);
      step(mk(32'h84, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0010), 1'b1, 1'b0, 1'b1);
      step(rand_op(), 1'b0, 1'b0, 1'b0);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_cnt", retired_cnt, base);
      idle(1);

      // Shifts, compares, SUB and an unused code, one per cycle
      step(mk(32'h0, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b0, 4'b1101), 1'b1, 1'b1, 1'b0);
      step(mk(32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0001), 1'b1, 1'b1, 1'b0);
      chk("sra", bus.out_alu, 32'hF800_0000);
      step(mk(32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0011), 1'b1, 1'b1, 1'b0);
      chk("slt", bus.out_alu, 32'd1);
      step(mk(32'h0, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 4'b1000), 1'b1, 1'b1, 1'b0);
      chk("sltu", bus.out_alu, 32'd0);
      step(mk(32'h0, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 4'b1111), 1'b1, 1'b1, 1'b0);
      chk("sub", bus.out_alu, 32'hFFFF_FFFF);
      step(rand_op(), 1'b0, 1'b1, 1'b0);
      chk("code15", bus.out_alu, 32'd0);
      idle(1);

      // Async reset while an entry is held
      step(mk(32'hC0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 4'b0010), 1'b1, 1'b0, 1'b0);
      step(mk(32'hC4, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'b0010), 1'b1, 1'b0, 1'b0);
      chk("pre_rst_alu", bus.out_alu, 32'd30);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_alu", bus.out_alu, 32'd0);
      chk("mid_rst_pc4", bus.out_pc4, 32'd0);
      chk("mid_rst_store", bus.out_store, 32'd0);
      chk("mid_rst_cnt", retired_cnt, 32'd0);
      q.delete();
      pend_ok       = 1'b0;
      exp_cnt       = 32'd0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(rand_op(), 1'b1, 1'b1, 1'b0);
      idle(2);
      chk("stream_cnt", retired_cnt, 32'd6);

      // Randomized traffic with backpressure and occasional flushes
      for (int i = 0; i < 400; i++)
         step(rand_op(), 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 75),
              1'($urandom_range(0, 99) < 6));
      idle(3);
      chk("drained", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
